// File: rtl/mat_vec_pkg.sv
// Shared types and sizing helpers for the matrix-vector engine.
package mat_vec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Wide enough for a full-column sum of unsigned products without wrapping.
   function automatic int acc_width(input int data_width, input int cols);
      return 2 * data_width + $clog2(cols);
   endfunction

endpackage

// File: rtl/mac_pe.sv
// One MAC lane: signed/unsigned multiply, extend, wrapping accumulate, and a
// one-cycle register that forwards B to the next lane.
module mac_pe #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 19
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  en,
   input  logic                  signed_mode,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b_in,
   output logic [DATA_WIDTH-1:0] b_out,
   output logic [ACC_WIDTH-1:0]  acc
);

   localparam int PROD_W = 2 * DATA_WIDTH + 2;
   localparam int EXT_W  = (ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W;

   logic signed [DATA_WIDTH:0]   a_ext;
   logic signed [DATA_WIDTH:0]   b_ext;
   logic signed [PROD_W-1:0]     prod;
   logic signed [ACC_WIDTH-1:0]  acc_d, acc_q;
   logic        [DATA_WIDTH-1:0] b_d, b_q;

   // One extra top bit lets a single signed multiplier serve both modes.
   function automatic logic signed [DATA_WIDTH:0] extend_op(input logic [DATA_WIDTH-1:0] v,
                                                            input logic is_signed);
      return {is_signed & v[DATA_WIDTH-1], v};
   endfunction

   function automatic logic signed [ACC_WIDTH-1:0] wrap_to_acc(input logic signed [PROD_W-1:0] p);
      logic signed [EXT_W-1:0] e;
      e = EXT_W'(p);
      return e[ACC_WIDTH-1:0];
   endfunction

   always_comb begin
      a_ext = extend_op(a, signed_mode);
      b_ext = extend_op(b_in, signed_mode);
      prod  = PROD_W'(a_ext) * PROD_W'(b_ext);
      acc_d = acc_q;
      b_d   = b_in;
      if (clr) begin
         acc_d = '0;
         b_d   = '0;
      end else if (en) begin
         acc_d = acc_q + wrap_to_acc(prod);
      end
   end

   always_ff @(posedge clk) begin
      acc_q <= acc_d;
      b_q   <= b_d;
   end

   assign acc   = acc_q;
   assign b_out = b_q;

endmodule

// File: rtl/mat_vec_engine.sv
// Matrix-vector multiply: column-wise load into per-row buffers, then a
// skewed systolic pass where B ripples down one lane per cycle.
module mat_vec_engine
   import mat_vec_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, COLS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [ROWS*DATA_WIDTH-1:0]   wr_a,
   input  logic [DATA_WIDTH-1:0]        wr_b,
   input  logic                         start,
   input  logic                         signed_mode,
   output logic                         busy,
   output logic                         done,
   output logic                         result_valid,
   output logic [ROWS*ACC_WIDTH-1:0]    result
);

   localparam int RUN_LEN = COLS + ROWS - 1;
   localparam int LAST_K  = RUN_LEN - 1;
   localparam int KW      = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
   localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int NW      = $clog2(COLS + 1);

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [NW-1:0]   cnt_q, cnt_d;
   logic            sm_q, sm_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            rv_q, rv_d;
   logic            wr_ready_q, wr_ready_d;

   logic            kill;
   logic            loaded;
   logic            start_acc;
   logic            wr_acc;
   logic            pe_clr;

   logic [DATA_WIDTH-1:0] a_buf_q [ROWS][COLS];
   logic [DATA_WIDTH-1:0] a_buf_d [ROWS][COLS];
   logic [DATA_WIDTH-1:0] b_buf_q [COLS];
   logic [DATA_WIDTH-1:0] b_buf_d [COLS];

   logic [DATA_WIDTH-1:0] lane_a     [ROWS];
   logic                  lane_en    [ROWS];
   logic [DATA_WIDTH-1:0] lane_b_out [ROWS];
   logic [DATA_WIDTH-1:0] b_lane0;
   logic                  lane_b_unused;

   always_comb begin
      kill      = rst | clr;
      loaded    = (cnt_q == NW'(COLS));
      start_acc = !kill && (state_q == ST_IDLE) && loaded && start;
      wr_acc    = !kill && wr_ready_q && wr_valid;
      pe_clr    = kill | start_acc;
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      sm_d    = sm_q;
      rv_d    = rv_q;
      if (kill) begin
         state_d = ST_IDLE;
         k_d     = '0;
         cnt_d   = '0;
         rv_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_acc) begin
                  state_d = ST_RUN;
                  k_d     = '0;
                  rv_d    = 1'b0;
                  sm_d    = signed_mode;
               end else if (wr_acc) begin
                  cnt_d = cnt_q + NW'(1);
               end
            end
            ST_RUN: begin
               if (k_q == KW'(LAST_K)) begin
                  state_d = ST_DONE;
                  k_d     = '0;
                  rv_d    = 1'b1;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d     = (state_d == ST_RUN);
      done_d     = (state_d == ST_DONE);
      wr_ready_d = (state_d == ST_IDLE) && (cnt_d != NW'(COLS));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         k_q        <= '0;
         cnt_q      <= '0;
         sm_q       <= 1'b0;
         rv_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         cnt_q      <= cnt_d;
         sm_q       <= sm_d;
         rv_q       <= rv_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wr_ready_q <= wr_ready_d;
      end
   end

   // Buffer contents are not cleared; the column count alone marks them empty.
   always_comb begin
      a_buf_d = a_buf_q;
      b_buf_d = b_buf_q;
      if (wr_acc) begin
         for (int r = 0; r < ROWS; r++) begin
            a_buf_d[r][cnt_q[CW-1:0]] = wr_a[r*DATA_WIDTH +: DATA_WIDTH];
         end
         b_buf_d[cnt_q[CW-1:0]] = wr_b;
      end
   end

   always_ff @(posedge clk) begin
      a_buf_q <= a_buf_d;
      b_buf_q <= b_buf_d;
   end

   // Row r is skewed by r cycles, matching the delay of B through the lanes.
   always_comb begin
      b_lane0 = (int'(k_q) < COLS) ? b_buf_q[CW'(k_q)] : '0;
      for (int r = 0; r < ROWS; r++) begin
         lane_en[r] = (state_q == ST_RUN) && (int'(k_q) >= r) && (int'(k_q) <= r + COLS - 1);
         lane_a[r]  = lane_en[r] ? a_buf_q[r][CW'(int'(k_q) - r)] : '0;
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      logic [DATA_WIDTH-1:0] b_src;
      if (r == 0) begin : g_first
         assign b_src = b_lane0;
      end else begin : g_chain
         assign b_src = lane_b_out[r-1];
      end
      mac_pe #(
         .DATA_WIDTH (DATA_WIDTH),
         .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
         .clk         (clk),
         .clr         (pe_clr),
         .en          (lane_en[r]),
         .signed_mode (sm_q),
         .a           (lane_a[r]),
         .b_in        (b_src),
         .b_out       (lane_b_out[r]),
         .acc         (result[r*ACC_WIDTH +: ACC_WIDTH])
      );
   end

   assign lane_b_unused = ^lane_b_out[ROWS-1];

   assign wr_ready     = wr_ready_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign result_valid = rv_q;

endmodule

// File: tb/tb_mat_vec_engine.sv
// Bench for mat_vec_engine: transaction-level reference model plus directed
// and randomized load/compute sequences.
module tb_mat_vec_engine;

   localparam int DW   = 8;
   localparam int ROWS = 8;
   localparam int COLS = 8;
   localparam int ACC  = 19;

   logic                 clk;
   logic                 rst;
   logic                 clr;
   logic                 wr_valid;
   logic                 wr_ready;
   logic [ROWS*DW-1:0]   wr_a;
   logic [DW-1:0]        wr_b;
   logic                 start;
   logic                 signed_mode;
   logic                 busy;
   logic                 done;
   logic                 result_valid;
   logic [ROWS*ACC-1:0]  result;

   mat_vec_engine #(
      .DATA_WIDTH (DW),
      .ROWS       (ROWS),
      .COLS       (COLS),
      .ACC_WIDTH  (ACC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_a         (wr_a),
      .wr_b         (wr_b),
      .start        (start),
      .signed_mode  (signed_mode),
      .busy         (busy),
      .done         (done),
      .result_valid (result_valid),
      .result       (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // stimulus tables: ta[r][c] is A, tbv[c] is B
   logic [DW-1:0] ta  [ROWS][COLS];
   logic [DW-1:0] tbv [COLS];

   // reference model state (transaction level)
   int             m_cnt   = 0;
   int             m_left  = 0;
   bit             m_done  = 1'b0;
   bit             m_rv    = 1'b0;
   bit             m_known = 1'b0;
   bit             m_sm    = 1'b0;
   logic [DW-1:0]  mA [ROWS][COLS];
   logic [DW-1:0]  mB [COLS];
   logic [ACC-1:0] m_res [ROWS];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [ACC-1:0] dot(input logic [DW-1:0] a [COLS], input logic [DW-1:0] b [COLS],
                                          input bit sm);
      longint s;
      longint x;
      longint y;
      logic [63:0] t;
      s = 0;
      for (int c = 0; c < COLS; c++) begin
         x = sm ? longint'($signed(a[c])) : longint'(a[c]);
         y = sm ? longint'($signed(b[c])) : longint'(b[c]);
         s += x * y;
      end
      t = s;
      return t[ACC-1:0];
   endfunction

   function automatic logic [ACC-1:0] expect_row(input int r, input bit sm);
      logic [DW-1:0] row [COLS];
      for (int c = 0; c < COLS; c++) row[c] = ta[r][c];
      return dot(row, tbv, sm);
   endfunction

   function automatic logic [ACC-1:0] model_row(input int r);
      logic [DW-1:0] row [COLS];
      for (int c = 0; c < COLS; c++) row[c] = mA[r][c];
      return dot(row, mB, m_sm);
   endfunction

   function automatic logic [ACC-1:0] dut_row(input int r);
      return result[r*ACC +: ACC];
   endfunction

   // reference model: a run is COLS+ROWS-1 busy cycles, then one done cycle
   always @(posedge clk) begin
      if (rst || clr) begin
         m_cnt   <= 0;
         m_left  <= 0;
         m_done  <= 1'b0;
         m_rv    <= 1'b0;
         m_known <= 1'b1;
         for (int r = 0; r < ROWS; r++) m_res[r] <= '0;
      end else if (m_done) begin
         m_done <= 1'b0;
         m_cnt  <= 0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done  <= 1'b1;
            m_rv    <= 1'b1;
            m_known <= 1'b1;
            for (int r = 0; r < ROWS; r++) m_res[r] <= model_row(r);
         end
      end else if (start && m_cnt == COLS) begin
         m_left  <= COLS + ROWS - 1;
         m_rv    <= 1'b0;
         m_known <= 1'b0;
         m_sm    <= signed_mode;
      end else if (wr_valid && m_cnt < COLS) begin
         for (int r = 0; r < ROWS; r++) mA[r][m_cnt] <= wr_a[r*DW +: DW];
         mB[m_cnt] <= wr_b;
         m_cnt     <= m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("wr_ready", wr_ready, (m_left == 0 && !m_done && m_cnt < COLS));
         check("busy", busy, (m_left > 0));
         check("done", done, m_done);
         check("result_valid", result_valid, m_rv);
         if (m_known) begin
            for (int r = 0; r < ROWS; r++) check($sformatf("result[%0d]", r), dut_row(r), m_res[r]);
         end
      end
   end

   task automatic write_col(input int c);
      wr_valid = 1'b1;
      for (int r = 0; r < ROWS; r++) wr_a[r*DW +: DW] = ta[r][c];
      wr_b = tbv[c];
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic load_all();
      for (int c = 0; c < COLS; c++) write_col(c);
   endtask

   task automatic start_only(input bit sm);
      start       = 1'b1;
      signed_mode = sm;
      @(negedge clk);
      start       = 1'b0;
      signed_mode = ~sm;
   endtask

   task automatic run_and_wait(input bit sm, input bit noise, output int lat);
      start_only(sm);
      lat = 1;
      check("busy_after_start", busy, 1);
      check("rv_clear_on_start", result_valid, 0);
      while (!done && lat < 40) begin
         if (noise) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_a     = {$urandom, $urandom};
            wr_b     = DW'($urandom);
            start    = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         lat++;
      end
      wr_valid = 1'b0;
      start    = 1'b0;
      check("done_seen", done, 1);
   endtask

   task automatic fill(input logic [DW-1:0] a, input logic [DW-1:0] b);
      for (int c = 0; c < COLS; c++) begin
         for (int r = 0; r < ROWS; r++) ta[r][c] = a;
         tbv[c] = b;
      end
   endtask

   task automatic fill_random();
      for (int c = 0; c < COLS; c++) begin
         for (int r = 0; r < ROWS; r++) ta[r][c] = DW'($urandom);
         tbv[c] = DW'($urandom);
      end
   endtask

   task automatic check_rows_const(input string name, input logic [ACC-1:0] exp);
      for (int r = 0; r < ROWS; r++) check($sformatf("%s[%0d]", name, r), dut_row(r), exp);
   endtask

   task automatic abort_test(input bit use_rst);
      bit seen;
      fill_random();
      load_all();
      start_only(1'b0);
      repeat (5) @(negedge clk);
      if (use_rst) rst = 1'b1;
      else clr = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clr = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_rv", result_valid, 0);
      check("abort_wr_ready", wr_ready, 1);
      check_rows_const("abort_result", '0);
      seen = 1'b0;
      repeat (20) begin
         if (done) seen = 1'b1;
         @(negedge clk);
      end
      check("abort_no_done", seen, 0);
   endtask

   int  lat;
   bit  sm;
   int  c;

   initial begin
      rst = 1'b1; clr = 1'b0; wr_valid = 1'b0; wr_a = '0; wr_b = '0;
      start = 1'b0; signed_mode = 1'b0;
      @(posedge clk);
      #1 cmp_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_wr_ready", wr_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_rv", result_valid, 0);
      check_rows_const("reset_result", '0);

      fill(8'd1, 8'd1);
      load_all();
      run_and_wait(1'b0, 1'b0, lat);
      check("latency_ones", lat, 16);
      check_rows_const("ones", 19'd8);
      @(negedge clk);

      fill(8'hFF, 8'd2);
      load_all();
      run_and_wait(1'b1, 1'b0, lat);
      check_rows_const("neg_signed", 19'h7FFF0);
      @(negedge clk);
      load_all();
      run_and_wait(1'b0, 1'b0, lat);
      check_rows_const("neg_unsigned", 19'h00FF0);
      @(negedge clk);

      fill(8'hFF, 8'hFF);
      load_all();
      run_and_wait(1'b0, 1'b0, lat);
      check_rows_const("max_unsigned", 19'h7F008);
      @(negedge clk);

      for (int cc = 0; cc < COLS; cc++) begin
         for (int r = 0; r < ROWS; r++) ta[r][cc] = DW'(r + 1);
         tbv[cc] = DW'(cc + 1);
      end
      load_all();
      run_and_wait(1'b0, 1'b0, lat);
      for (int r = 0; r < ROWS; r++) check($sformatf("row_distinct[%0d]", r), dut_row(r), 36 * (r + 1));
      @(negedge clk);

      // partial load, start on the last-column cycle, and an overflow write
      fill_random();
      for (int cc = 0; cc < COLS - 1; cc++) write_col(cc);
      start_only(1'b0);
      check("start_7cols_busy", busy, 0);
      check("start_7cols_ready", wr_ready, 1);
      start = 1'b1;
      write_col(COLS - 1);
      start = 1'b0;
      check("start_lastcol_busy", busy, 0);
      check("full_wr_ready", wr_ready, 0);
      wr_valid = 1'b1;
      wr_a     = ~{ta[0][0], ta[1][0], ta[2][0], ta[3][0], ta[4][0], ta[5][0], ta[6][0], ta[7][0]};
      wr_b     = ~tbv[0];
      @(negedge clk);
      wr_valid = 1'b0;
      check("overflow_wr_ready", wr_ready, 0);
      run_and_wait(1'b0, 1'b0, lat);
      for (int r = 0; r < ROWS; r++) check($sformatf("overflow_kept[%0d]", r), dut_row(r), expect_row(r, 1'b0));
      @(negedge clk);

      abort_test(1'b0);
      abort_test(1'b1);

      // randomized loads with gaps, ignored starts, and noise during the run
      for (int it = 0; it < 6; it++) begin
         fill_random();
         sm = 1'($urandom_range(0, 1));
         c  = 0;
         while (c < COLS) begin
            if ($urandom_range(0, 3) == 0) begin
               wr_valid = 1'b0;
               wr_a     = {$urandom, $urandom};
               start    = 1'($urandom_range(0, 1));
               @(negedge clk);
               start    = 1'b0;
            end else begin
               write_col(c);
               c++;
            end
         end
         if (it == 3) begin
            start = 1'b1;
            clr   = 1'b1;
            @(negedge clk);
            start = 1'b0;
            clr   = 1'b0;
            check("clr_beats_start", busy, 0);
            load_all();
         end
         run_and_wait(sm, 1'b1, lat);
         check("latency_rand", lat, 16);
         for (int r = 0; r < ROWS; r++) check($sformatf("rand%0d[%0d]", it, r), dut_row(r), expect_row(r, sm));
         @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mat_vec_engine.md
MAT_VEC_ENGINE -- requirements
Module: mat_vec_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 8: element width of A and B.
REQ-002 Parameter ROWS, default 8: matrix rows, MAC lanes and result count.
REQ-003 Parameter COLS, default 8: matrix columns, vector length and buffer depth.
REQ-004 Parameter ACC_WIDTH, default 2*DATA_WIDTH+$clog2(COLS) (19): accumulator and result width.
REQ-005 The module SHALL use one clock and a synchronous, active-high reset, with ports named as below.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 clr  in  1  synchronous soft clear with the same effect as rst.
REQ-009 wr_valid  in  1  column write request.
REQ-010 wr_ready  out  1  column write accepted when high together with wr_valid.
REQ-011 wr_a  in  ROWS x DATA_WIDTH  one matrix column; element r goes to row r.
REQ-012 wr_b  in  DATA_WIDTH  vector element matching that column.
REQ-013 start  in  1  compute request.
REQ-014 signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled when start is accepted.
REQ-015 busy  out  1  high while computing.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 result_valid  out  1  high when result holds a completed product.
REQ-018 result  out  ROWS x ACC_WIDTH  result[r] = sum over c of A[r][c]*B[c].

Function
REQ-019 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-020 IDLE SHALL assert wr_ready while fewer than COLS columns are stored; each accepted write stores one column per row plus one B element.
REQ-021 The "loaded" condition SHALL become true on the edge that stores column COLS-1; wr_ready SHALL be 0 from the next cycle.
REQ-022 In IDLE with loaded=1, start SHALL be accepted: IDLE->RUN, accumulators zeroed, result_valid cleared, signed_mode latched.
REQ-023 start SHALL be ignored when loaded=0, including in the cycle that stores the last column, and in RUN or DONE.
REQ-024 RUN SHALL last exactly COLS+ROWS-1 cycles, counted by run counter k = 0 .. COLS+ROWS-2.
REQ-025 Row r SHALL accumulate on cycle k only when r <= k <= r+COLS-1, using column k-r of its buffer.
REQ-026 B SHALL enter lane 0 at k = c and pass lane-to-lane through a one-cycle register per lane, so row r sees B[c] at k = c+r.
REQ-027 RUN->DONE SHALL follow k = COLS+ROWS-2; in DONE, done=1 and result_valid is set.
REQ-028 DONE->IDLE SHALL be unconditional, with buffers empty (loaded=0, wr_ready=1).
REQ-029 done SHALL rise exactly COLS+ROWS cycles after the start-accept edge (16 cycles at defaults).
REQ-030 busy SHALL equal (state==RUN).
REQ-031 wr_ready SHALL be 0 in RUN and DONE.
REQ-032 Products SHALL be sign-extended (signed) or zero-extended (unsigned) to ACC_WIDTH.
REQ-033 Accumulation SHALL wrap modulo 2^ACC_WIDTH.
REQ-034 result SHALL hold its value until the next accepted start, clr or rst.
REQ-035 clr SHALL take priority over start and wr_valid in the same cycle.

Reset
REQ-036 On rst or clr, on the next edge: state=IDLE, buffers empty, run counter 0, accumulators and B pipeline 0.
REQ-037 Outputs after rst or clr: wr_ready=1, busy=0, done=0, result_valid=0, result all-zero.
REQ-038 rst or clr asserted mid-RUN SHALL abort the run, with no done pulse.

Structure
REQ-039 Package mat_vec_pkg SHALL hold the state enum and an acc_width function.
REQ-040 Sub-module mac_pe SHALL implement one lane: multiply, extend, accumulate, clear, and the B pass-through register. It is instantiated ROWS times.
REQ-041 Per-row column buffers and the FSM SHALL reside in mat_vec_engine.

Verification
REQ-042 Unsigned, all A=1, B=1: result[r]=8 for all r; done exactly 16 cycles after start accepted.
REQ-043 A=8'hFF, B=2, signed_mode=1: result[r]=19'h7FFF0 (-16). Repeat with signed_mode=0: result[r]=19'h00FF0 (4080).
REQ-044 Unsigned, A=B=8'hFF: result[r]=19'h7F008 (520200), no wrap. Row-distinct test with A[r][c]=r+1, B[c]=c+1: result[r]=36*(r+1).
REQ-045 start with 7 columns stored: ignored, busy stays 0. 9th wr_valid after 8 writes: wr_ready=0, buffer unchanged.
REQ-046 clr at run cycle k=5: next cycle busy=0, result=0, result_valid=0, wr_ready=1, and no done. rst mid-run gives the same response.
REQ-047 A second full load and start after done: result_valid drops at start acceptance and the new result replaces the old.
